// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select, req/ack instruction fetch and IR latch.
// Optional IFETCH_ALIGN_CHECK_EN traps misaligned PC targets into a sticky fault.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  Code,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic        ir_pending,
  output logic        fault
);

  typedef enum logic {S_FETCH, S_VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] buf_q, buf_d;
  logic        stale_q, stale_d;
  logic        pend_q, pend_d;
  logic        fault_q, fault_d;

  logic [31:0] pc4, br_off, next_raw, next_pc;
  logic        pc_we, ir_we, fault_set, active, ack_ok;

  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    case (PCSrc)
      2'd0:    next_raw = pc4;
      2'd1:    next_raw = pc4 + br_off;
      2'd2:    next_raw = rs_data;
      default: next_raw = {pc4[31:28], ir_q[25:0], 2'b00};
    endcase
`ifdef IFETCH_ALIGN_CHECK_EN
    next_pc   = next_raw;
    active    = !fault_q;
    fault_set = active && PCWre && (next_raw[1:0] != 2'b00);
    pc_we     = active && PCWre && (next_raw[1:0] == 2'b00);
    ir_we     = active && IRWre;
`else
    next_pc   = next_raw & ~32'h3;
    active    = 1'b1;
    fault_set = 1'b0;
    pc_we     = PCWre;
    ir_we     = IRWre;
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    buf_d   = buf_q;
    stale_d = stale_q;
    pend_d  = pend_q;
    fault_d = fault_q | fault_set;
    // A redirect on the ack edge also invalidates the returning word.
    ack_ok  = active && (state_q == S_FETCH) && imem_ack && !stale_q && !pc_we;

    if (pc_we) pc_d = next_pc;

    if (active) begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            stale_d = 1'b0;
            if (ack_ok) begin
              buf_d   = imem_rdata;
              state_d = S_VALID;
            end
          end else if (pc_we) begin
            stale_d = 1'b1;
          end
        end
        default: if (pc_we) state_d = S_FETCH;
      endcase
    end

    if (ir_we && (state_q == S_VALID)) begin
      ir_d = buf_q;
    end else if (ack_ok && (pend_q || ir_we)) begin
      ir_d   = imem_rdata;
      pend_d = 1'b0;
    end else if (ir_we) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      buf_q   <= 32'h0;
      stale_q <= 1'b0;
      pend_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      buf_q   <= buf_d;
      stale_q <= stale_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH) && !fault_q;
  assign imem_addr  = pc_q;
  assign if_ready   = (state_q == S_VALID);
  assign pc         = pc_q;
  assign pc_plus4   = pc4;
  assign Code       = ir_q[31:26];
  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign rd         = ir_q[15:11];
  assign sa         = ir_q[10:6];
  assign imm        = ir_q[15:0];
  assign ir_pending = pend_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed fetch/branch/redirect/pending/reset cases, then random
// CU and memory-latency stimulus against a transaction-level model checked every cycle.
module tb_ifetch_unit;

  logic        CLK, RST, PCWre, IRWre, imem_ack;
  logic [1:0]  PCSrc;
  logic [31:0] rs_data, imem_rdata;
  logic        imem_req, if_ready, ir_pending, fault;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [5:0]  Code;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  ifetch_unit #(.RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc),
    .rs_data(rs_data), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_ready(if_ready),
    .pc(pc), .pc_plus4(pc_plus4), .Code(Code), .rs(rs), .rt(rt), .rd(rd),
    .sa(sa), .imm(imm), .ir_pending(ir_pending), .fault(fault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vec = 0, miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a few fixed words, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0822_0005;
      32'h0000_0008: return 32'h1111_2222;
      32'h0000_0010: return 32'h1000_FFFE;
      32'h0000_0020: return 32'h2444_0020;
      32'h0000_0040: return 32'h8C41_0004;
      32'h1000_0000: return 32'h0800_0010;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Memory responder: latches the address when a request starts, acks after a wait.
  bit          fresh = 1'b1, rand_wait = 1'b0;
  int          cnt = 0, nwait = 0;
  logic [31:0] lat_addr;

  task automatic respond();
    if (!RST || !imem_req) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (!RST) fresh = 1'b1;
    end else begin
      if (fresh) begin
        cnt      = rand_wait ? int'($urandom_range(0, 3)) : nwait;
        lat_addr = imem_addr;
        fresh    = 1'b0;
      end
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(lat_addr);
        fresh      = 1'b1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        cnt--;
      end
    end
  endtask

  task automatic tick(input bit rst_n, input bit pcw, input bit irw,
                      input logic [1:0] src, input logic [31:0] rsd);
    @(negedge CLK);
    RST = rst_n; PCWre = pcw; IRWre = irw; PCSrc = src; rs_data = rsd;
    respond();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: the PC plus a generation count; a fetch is useful only if the
  // request was issued under the current generation and no redirect lands on its ack.
  logic [31:0] m_pc, m_ir, m_buf;
  bit          m_have, m_pend, m_fault, m_outst, m_valid = 1'b0;
  int unsigned m_gen, m_tag;

  always @(posedge CLK) begin : model
    logic [31:0] pc4, np;
    bit req, upd, fset, acc;
    if (!RST) begin
      m_pc = 32'h0; m_ir = 32'h0; m_buf = 32'h0;
      m_have = 0; m_pend = 0; m_fault = 0; m_outst = 0; m_gen = 0; m_tag = 0;
      m_valid = 1'b1;
    end else if (m_valid && !m_fault) begin
      pc4 = m_pc + 4;
      case (PCSrc)
        2'd0: np = pc4;
        2'd1: np = pc4 + {{14{m_ir[15]}}, m_ir[15:0], 2'b00};
        2'd2: np = rs_data;
        default: np = {pc4[31:28], m_ir[25:0], 2'b00};
      endcase
`ifdef IFETCH_ALIGN_CHECK_EN
      fset = PCWre && (np[1:0] != 2'b00);
      upd  = PCWre && !fset;
`else
      np   = {np[31:2], 2'b00};
      fset = 1'b0;
      upd  = PCWre;
`endif
      req = !m_have;
      if (req && !m_outst) begin
        m_outst = 1'b1;
        m_tag   = m_gen;
      end
      acc = req && imem_ack && (m_tag == m_gen) && !upd;
      if (req && imem_ack) m_outst = 1'b0;
      if (IRWre && m_have) m_ir = m_buf;
      else if (acc && (m_pend || IRWre)) begin
        m_ir = imem_rdata; m_pend = 1'b0;
      end else if (IRWre) m_pend = 1'b1;
      if (acc) begin
        m_have = 1'b1; m_buf = imem_rdata;
      end
      if (upd) begin
        m_have = 1'b0; m_pc = np; m_gen++;
      end
      if (fset) m_fault = 1'b1;
    end
  end

  always @(posedge CLK) begin : compare
    #1;
    if (m_valid) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_have && !m_fault});
      if (!m_have && !m_fault) chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("if_ready", {31'b0, if_ready}, {31'b0, m_have});
      chk("ir_pending", {31'b0, ir_pending}, {31'b0, m_pend});
      chk("fault", {31'b0, fault}, {31'b0, m_fault});
      chk("ir_fields", {Code, rs, rt, imm}, m_ir);
      chk("rd_sa", {22'b0, rd, sa}, {22'b0, m_ir[15:6]});
    end
  end

  initial begin
    RST = 1'b0; PCWre = 1'b0; IRWre = 1'b0; PCSrc = 2'd0; rs_data = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // reset and first fetch with zero-wait memory
    nwait = 0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_code", {26'b0, Code}, 32'h0);
    chk("rst_pend", {31'b0, ir_pending}, 32'h0);
    chk("rst_ready", {31'b0, if_ready}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    tick(1, 0, 0, 0, 0);
    chk("ready0", {31'b0, if_ready}, 32'h1);
    tick(1, 0, 1, 0, 0);
    chk("code0", {26'b0, Code}, 32'h2);
    chk("rs0", {27'b0, rs}, 32'h1);
    chk("rt0", {27'b0, rt}, 32'h2);
    chk("imm0", {16'b0, imm}, 32'h5);

    // backward branch from 0x10 with imm=-2
    tick(1, 1, 0, 2, 32'h10);
    chk("jr_pc", pc, 32'h10);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 0, 1, 0);
    chk("beq_pc", pc, 32'h0000_000C);

    // jump keeping PC+4[31:28]
    tick(1, 1, 0, 2, 32'h1000_0000);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 0, 3, 0);
    chk("j_pc", pc, 32'h1000_0040);

    // redirect during a 3-wait fetch at 0x08
    tick(1, 1, 0, 2, 32'h08);
    nwait = 3;
    tick(1, 0, 0, 0, 0);
    nwait = 0;
    tick(1, 1, 0, 2, 32'h20);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("stale_ready", {31'b0, if_ready}, 32'h0);
    chk("stale_req", {31'b0, imem_req}, 32'h1);
    chk("stale_addr", imem_addr, 32'h20);
    tick(1, 0, 0, 0, 0);
    chk("redir_ready", {31'b0, if_ready}, 32'h1);
    tick(1, 0, 1, 0, 0);
    chk("redir_code", {26'b0, Code}, 32'h09);
    chk("redir_imm", {16'b0, imm}, 32'h20);

    // IRWre during a 2-wait fetch is deferred to the ack edge
    nwait = 2;
    tick(1, 1, 0, 2, 32'h40);
    tick(1, 0, 1, 0, 0);
    chk("pend_set", {31'b0, ir_pending}, 32'h1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("pend_clr", {31'b0, ir_pending}, 32'h0);
    chk("pend_ready", {31'b0, if_ready}, 32'h1);
    chk("pend_code", {26'b0, Code}, 32'h23);
    chk("pend_imm", {16'b0, imm}, 32'h4);

    // reset in the middle of a fetch with a deferred IR load outstanding
    nwait = 5;
    tick(1, 1, 0, 2, 32'h80);
    tick(1, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("mid_pc", pc, 32'h0);
    chk("mid_addr", imem_addr, 32'h0);
    chk("mid_code", {26'b0, Code}, 32'h0);
    chk("mid_pend", {31'b0, ir_pending}, 32'h0);

    // misaligned JR target
    nwait = 0;
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 2, 32'h6);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("al_fault", {31'b0, fault}, 32'h1);
    chk("al_pc", pc, 32'h0);
    chk("al_req", {31'b0, imem_req}, 32'h0);
`else
    chk("al_pc", pc, 32'h4);
    chk("al_fault", {31'b0, fault}, 32'h0);
`endif

    // random CU activity and memory latency
    rand_wait = 1'b1;
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      tick($urandom_range(0, 299) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
